// File: rtl/apb2axi_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb2axi_bridge_if : APB3 completer bundle plus single-beat AXI4 manager    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface apb2axi_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int APB_ADDR_WIDTH = 32
);
  // APB
  logic                        psel_i;
  logic                        penable_i;
  logic                        pwrite_i;
  logic [APB_ADDR_WIDTH-1:0]   paddr_i;
  logic [31:0]                 pwdata_i;
  logic [31:0]                 prdata_o;
  logic                        pready_o;
  logic                        pslverr_o;
  // AW
  logic                        aw_valid_o;
  logic                        aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o;
  logic [AXI_ID_WIDTH-1:0]     aw_id_o;
  logic [7:0]                  aw_len_o;
  logic [2:0]                  aw_size_o;
  logic [1:0]                  aw_burst_o;
  logic                        aw_lock_o;
  logic [3:0]                  aw_cache_o;
  logic [2:0]                  aw_prot_o;
  logic [3:0]                  aw_region_o;
  logic [3:0]                  aw_qos_o;
  logic [AXI_USER_WIDTH-1:0]   aw_user_o;
  logic [5:0]                  aw_atop_o;
  // W
  logic                        w_valid_o;
  logic                        w_ready_i;
  logic [AXI_DATA_WIDTH-1:0]   w_data_o;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_o;
  logic                        w_last_o;
  logic [AXI_USER_WIDTH-1:0]   w_user_o;
  // B
  logic                        b_valid_i;
  logic                        b_ready_o;
  logic [1:0]                  b_resp_i;
  logic [AXI_ID_WIDTH-1:0]     b_id_i;
  logic [AXI_USER_WIDTH-1:0]   b_user_i;
  // AR
  logic                        ar_valid_o;
  logic                        ar_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o;
  logic [AXI_ID_WIDTH-1:0]     ar_id_o;
  logic [7:0]                  ar_len_o;
  logic [2:0]                  ar_size_o;
  logic [1:0]                  ar_burst_o;
  logic                        ar_lock_o;
  logic [3:0]                  ar_cache_o;
  logic [2:0]                  ar_prot_o;
  logic [3:0]                  ar_region_o;
  logic [3:0]                  ar_qos_o;
  logic [AXI_USER_WIDTH-1:0]   ar_user_o;
  // R
  logic                        r_valid_i;
  logic                        r_ready_o;
  logic [AXI_DATA_WIDTH-1:0]   r_data_i;
  logic [1:0]                  r_resp_i;
  logic [AXI_ID_WIDTH-1:0]     r_id_i;
  logic                        r_last_i;
  logic [AXI_USER_WIDTH-1:0]   r_user_i;

  // Bridge side: APB completer, AXI manager
  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o,
    output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o,
           aw_cache_o, aw_prot_o, aw_region_o, aw_qos_o, aw_user_o, aw_atop_o,
    input  aw_ready_i,
    output w_valid_o, w_data_o, w_strb_o, w_last_o, w_user_o,
    input  w_ready_i,
    input  b_valid_i, b_resp_i, b_id_i, b_user_i,
    output b_ready_o,
    output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o,
           ar_cache_o, ar_prot_o, ar_region_o, ar_qos_o, ar_user_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i, r_id_i, r_last_i, r_user_i,
    output r_ready_o
  );

  // Environment side: APB requester, AXI subordinate
  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o,
    input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o,
           aw_cache_o, aw_prot_o, aw_region_o, aw_qos_o, aw_user_o, aw_atop_o,
    output aw_ready_i,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o, w_user_o,
    output w_ready_i,
    output b_valid_i, b_resp_i, b_id_i, b_user_i,
    input  b_ready_o,
    input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o,
           ar_cache_o, ar_prot_o, ar_region_o, ar_qos_o, ar_user_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i, r_id_i, r_last_i, r_user_i,
    input  r_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/apb2axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb2axi_bridge : single-outstanding APB3 completer to AXI4 manager bridge  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb2axi_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int APB_ADDR_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  apb2axi_bridge_if.slave      bus
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    READ    = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                    state_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               prdata_q;
  logic                      pready_q;
  logic                      pslverr_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      b_ready_q;
  logic                      ar_valid_q;
  logic                      r_ready_q;

  logic [31:0]               rlane;
  logic [STRB_WIDTH-1:0]     wstrb;
  logic [AXI_DATA_WIDTH-1:0] wdata_bus;

  generate
    if (AXI_DATA_WIDTH == 64) begin : g_dw64
      // The 32-bit word is replicated on both lanes; paddr[2] picks the live one
      assign wdata_bus = {wdata_q, wdata_q};
      assign wstrb     = addr_q[2] ? 8'hF0 : 8'h0F;
      assign rlane     = addr_q[2] ? bus.r_data_i[63:32] : bus.r_data_i[31:0];
    end else begin : g_dw32
      assign wdata_bus = wdata_q;
      assign wstrb     = '1;
      assign rlane     = bus.r_data_i[31:0];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.psel_i && !bus.penable_i) begin
            addr_q  <= {bus.paddr_i[APB_ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= bus.pwdata_i;
            if (bus.pwrite_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WRITE;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        WRITE: begin
          // A dropped valid marks its channel as already done
          if (aw_valid_q && bus.aw_ready_i) aw_valid_q <= 1'b0;
          if (w_valid_q && bus.w_ready_i)   w_valid_q  <= 1'b0;
          if ((!aw_valid_q || bus.aw_ready_i) && (!w_valid_q || bus.w_ready_i)) begin
            b_ready_q <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.b_valid_i) begin
            b_ready_q <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= bus.b_resp_i[1];
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        READ: begin
          if (bus.ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.r_valid_i) begin
            r_ready_q <= 1'b0;
            prdata_q  <= rlane;
            pslverr_q <= bus.r_resp_i[1];
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.prdata_o    = prdata_q;
  assign bus.pready_o    = pready_q;
  assign bus.pslverr_o   = pslverr_q;

  assign bus.aw_valid_o  = aw_valid_q;
  assign bus.aw_addr_o   = AXI_ADDR_WIDTH'(addr_q);
  assign bus.aw_id_o     = '0;
  assign bus.aw_len_o    = 8'd0;
  assign bus.aw_size_o   = 3'd2;
  assign bus.aw_burst_o  = 2'b01;
  assign bus.aw_lock_o   = 1'b0;
  assign bus.aw_cache_o  = 4'd0;
  assign bus.aw_prot_o   = 3'd0;
  assign bus.aw_region_o = 4'd0;
  assign bus.aw_qos_o    = 4'd0;
  assign bus.aw_user_o   = '0;
  assign bus.aw_atop_o   = 6'd0;

  assign bus.w_valid_o   = w_valid_q;
  assign bus.w_data_o    = wdata_bus;
  assign bus.w_strb_o    = wstrb;
  assign bus.w_last_o    = 1'b1;
  assign bus.w_user_o    = '0;

  assign bus.b_ready_o   = b_ready_q;

  assign bus.ar_valid_o  = ar_valid_q;
  assign bus.ar_addr_o   = AXI_ADDR_WIDTH'(addr_q);
  assign bus.ar_id_o     = '0;
  assign bus.ar_len_o    = 8'd0;
  assign bus.ar_size_o   = 3'd2;
  assign bus.ar_burst_o  = 2'b01;
  assign bus.ar_lock_o   = 1'b0;
  assign bus.ar_cache_o  = 4'd0;
  assign bus.ar_prot_o   = 3'd0;
  assign bus.ar_region_o = 4'd0;
  assign bus.ar_qos_o    = 4'd0;
  assign bus.ar_user_o   = '0;

  assign bus.r_ready_o   = r_ready_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.b_id_i, bus.b_user_i, bus.r_id_i, bus.r_last_i, bus.r_user_i,
                           bus.b_resp_i[0], bus.r_resp_i[0], bus.paddr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb2axi_bridge : 32-bit and 64-bit bridges driven in lockstep           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_apb2axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0, ar_ready = 1'b0, r_valid = 1'b0;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic [63:0] r_data = '0;

  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  resp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0;
  bit          unstable = 1'b0;
  logic [31:0] first_aw, first_ar, first_wd;
  logic [31:0] cap_aw32, cap_aw64, cap_ar32, cap_ar64, cap_wd32;
  logic [63:0] cap_wd64;
  logic [3:0]  cap_st32;
  logic [7:0]  cap_st64;

  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] prd32;
    logic [31:0] prd64;
    logic [31:0] wd;
    logic        err;
    logic [7:0]  st64;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  apb2axi_bridge_if #(.AXI_DATA_WIDTH(32)) if32 ();
  apb2axi_bridge_if #(.AXI_DATA_WIDTH(64)) if64 ();

  assign if32.psel_i = psel;       assign if64.psel_i = psel;
  assign if32.penable_i = penable; assign if64.penable_i = penable;
  assign if32.pwrite_i = pwrite;   assign if64.pwrite_i = pwrite;
  assign if32.paddr_i = paddr;     assign if64.paddr_i = paddr;
  assign if32.pwdata_i = pwdata;   assign if64.pwdata_i = pwdata;
  assign if32.aw_ready_i = aw_ready; assign if64.aw_ready_i = aw_ready;
  assign if32.w_ready_i = w_ready;   assign if64.w_ready_i = w_ready;
  assign if32.b_valid_i = b_valid;   assign if64.b_valid_i = b_valid;
  assign if32.b_resp_i = b_resp;     assign if64.b_resp_i = b_resp;
  assign if32.b_id_i = '0;           assign if64.b_id_i = '0;
  assign if32.b_user_i = '0;         assign if64.b_user_i = '0;
  assign if32.ar_ready_i = ar_ready; assign if64.ar_ready_i = ar_ready;
  assign if32.r_valid_i = r_valid;   assign if64.r_valid_i = r_valid;
  assign if32.r_data_i = r_data[31:0]; assign if64.r_data_i = r_data;
  assign if32.r_resp_i = r_resp;     assign if64.r_resp_i = r_resp;
  assign if32.r_id_i = '0;           assign if64.r_id_i = '0;
  assign if32.r_last_i = 1'b1;       assign if64.r_last_i = 1'b1;
  assign if32.r_user_i = '0;         assign if64.r_user_i = '0;

  apb2axi_bridge #(.AXI_DATA_WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32.slave));
  apb2axi_bridge #(.AXI_DATA_WIDTH(64)) dut64 (.clk_i(clk), .rst_i(rst), .bus(if64.slave));

  // AXI subordinate: each ready/valid is raised after a programmed number of waits
  always @(negedge clk) begin
    if (rst) begin
      aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (psel && !penable) begin
        aw_hi = 0; w_hi = 0; ar_hi = 0; unstable = 0;
        cap_aw32 = '1; cap_aw64 = '1; cap_ar32 = '1; cap_ar64 = '1;
        cap_wd32 = '1; cap_wd64 = '1; cap_st32 = '0; cap_st64 = '0;
      end
      if (if32.aw_valid_o) begin
        aw_hi++;
        if (aw_hi == 1) first_aw = if32.aw_addr_o;
        else if (if32.aw_addr_o !== first_aw) unstable = 1;
        aw_ready = (aw_cnt == aw_dly);
        if (aw_ready) begin cap_aw32 = if32.aw_addr_o; cap_aw64 = if64.aw_addr_o; end
        aw_cnt++;
      end else begin aw_ready = 0; aw_cnt = 0; end
      if (if32.w_valid_o) begin
        w_hi++;
        if (w_hi == 1) first_wd = if32.w_data_o;
        else if (if32.w_data_o !== first_wd) unstable = 1;
        w_ready = (w_cnt == w_dly);
        if (w_ready) begin
          cap_wd32 = if32.w_data_o; cap_wd64 = if64.w_data_o;
          cap_st32 = if32.w_strb_o; cap_st64 = if64.w_strb_o;
        end
        w_cnt++;
      end else begin w_ready = 0; w_cnt = 0; end
      if (if32.b_ready_o) begin
        b_valid = (b_cnt == b_dly); b_resp = resp_cfg; b_cnt++;
      end else begin b_valid = 0; b_cnt = 0; end
      if (if32.ar_valid_o) begin
        ar_hi++;
        if (ar_hi == 1) first_ar = if32.ar_addr_o;
        else if (if32.ar_addr_o !== first_ar) unstable = 1;
        ar_ready = (ar_cnt == ar_dly);
        if (ar_ready) begin cap_ar32 = if32.ar_addr_o; cap_ar64 = if64.ar_addr_o; end
        ar_cnt++;
      end else begin ar_ready = 0; ar_cnt = 0; end
      if (if32.r_ready_o) begin
        r_valid = (r_cnt == r_dly); r_data = rdata_cfg; r_resp = resp_cfg; r_cnt++;
      end else begin r_valid = 0; r_cnt = 0; end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit b2b);
    exp_t e;
    int   cyc;
    e.wr    = wr;
    e.addr  = a & 32'hFFFF_FFFC;
    e.wd    = d;
    e.err   = resp_cfg[1];
    e.prd32 = wr ? 32'h0 : rdata_cfg[31:0];
    e.prd64 = wr ? 32'h0 : (a[2] ? rdata_cfg[63:32] : rdata_cfg[31:0]);
    e.st64  = a[2] ? 8'hF0 : 8'h0F;
    e.lat   = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    exp_q.push_back(e);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!if32.pready_o && cyc < 100);
    e = exp_q.pop_front();
    n_tests++; if (cyc != e.lat) begin n_fail++; $display("FAIL latency a=%h got=%0d exp=%0d", e.addr, cyc, e.lat); end
    n_tests++; if (if64.pready_o !== 1'b1) begin n_fail++; $display("FAIL pready64 a=%h got=%b exp=1", e.addr, if64.pready_o); end
    n_tests++; if (if32.prdata_o !== e.prd32) begin n_fail++; $display("FAIL prdata32 a=%h got=%h exp=%h", e.addr, if32.prdata_o, e.prd32); end
    n_tests++; if (if64.prdata_o !== e.prd64) begin n_fail++; $display("FAIL prdata64 a=%h got=%h exp=%h", e.addr, if64.prdata_o, e.prd64); end
    n_tests++; if ({if32.pslverr_o, if64.pslverr_o} !== {2{e.err}}) begin n_fail++; $display("FAIL pslverr a=%h got=%b%b exp=%b", e.addr, if32.pslverr_o, if64.pslverr_o, e.err); end
    n_tests++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL stability a=%h got=changed exp=stable", e.addr); end
    if (e.wr) begin
      n_tests++; if ({cap_aw32, cap_aw64} !== {e.addr, e.addr}) begin n_fail++; $display("FAIL aw_addr got=%h/%h exp=%h", cap_aw32, cap_aw64, e.addr); end
      n_tests++; if ({cap_st32, cap_st64} !== {4'hF, e.st64}) begin n_fail++; $display("FAIL w_strb got=%h/%h exp=f/%h", cap_st32, cap_st64, e.st64); end
      n_tests++; if ({cap_wd32, cap_wd64} !== {e.wd, e.wd, e.wd}) begin n_fail++; $display("FAIL w_data got=%h/%h exp=%h", cap_wd32, cap_wd64, e.wd); end
    end else begin
      n_tests++; if ({cap_ar32, cap_ar64} !== {e.addr, e.addr}) begin n_fail++; $display("FAIL ar_addr got=%h/%h exp=%h", cap_ar32, cap_ar64, e.addr); end
    end
    @(posedge clk); #1;
    n_tests++; if ({if32.pready_o, if64.pready_o} !== 2'b00) begin n_fail++; $display("FAIL pready_pulse a=%h got=%b%b exp=00", e.addr, if32.pready_o, if64.pready_o); end
    if (!b2b) begin psel = 0; penable = 0; end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({if32.aw_valid_o, if32.w_valid_o, if32.b_ready_o, if32.ar_valid_o, if32.r_ready_o,
         if32.pready_o, if32.pslverr_o, if32.prdata_o} !== 39'd0) begin
      n_fail++; $display("FAIL reset32 got=%b exp=0", {if32.aw_valid_o, if32.w_valid_o, if32.b_ready_o, if32.ar_valid_o, if32.r_ready_o, if32.pready_o, if32.pslverr_o});
    end
    n_tests++;
    if ({if64.aw_valid_o, if64.w_valid_o, if64.b_ready_o, if64.ar_valid_o, if64.r_ready_o,
         if64.pready_o, if64.pslverr_o, if64.prdata_o} !== 39'd0) begin
      n_fail++; $display("FAIL reset64 got=%b exp=0", {if64.aw_valid_o, if64.w_valid_o, if64.b_ready_o, if64.ar_valid_o, if64.r_ready_o, if64.pready_o, if64.pslverr_o});
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_min;
    resp_cfg = 2'b00;
    n_tests++;
    if ({if32.aw_size_o, if32.aw_burst_o, if32.aw_len_o, if32.w_last_o, if64.ar_size_o} !== {3'd2, 2'b01, 8'd0, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL sideband got=%h/%h/%h exp=2/1/0", if32.aw_size_o, if32.aw_burst_o, if32.aw_len_o);
    end
    apb_xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_read_lane;
    rdata_cfg = 64'h1122_3344_5566_7788;
    resp_cfg  = 2'b00;
    apb_xfer(1'b0, 32'h0000_200C, 32'h0, 1'b0);
    apb_xfer(1'b0, 32'h0000_2008, 32'h0, 1'b0);
  endtask

  task automatic test_wait_states;
    aw_dly = 3;
    apb_xfer(1'b1, 32'h0000_3008, 32'h0F1E_2D3C, 1'b0);
    n_tests++; if (aw_hi !== 4) begin n_fail++; $display("FAIL aw_valid_len got=%0d exp=4", aw_hi); end
    n_tests++; if (w_hi !== 1) begin n_fail++; $display("FAIL w_valid_len got=%0d exp=1", w_hi); end
    aw_dly = 0; w_dly = 2; b_dly = 1;
    apb_xfer(1'b1, 32'h0000_3014, 32'h7654_3210, 1'b0);
    n_tests++; if (w_hi !== 3) begin n_fail++; $display("FAIL w_valid_len2 got=%0d exp=3", w_hi); end
    w_dly = 0; b_dly = 0;
  endtask

  task automatic test_read_err;
    rdata_cfg = 64'hCAFE_F00D_0BAD_BEEF;
    ar_dly = 2; r_dly = 1;
    resp_cfg = 2'b10; apb_xfer(1'b0, 32'h0000_2010, 32'h0, 1'b0);
    resp_cfg = 2'b11; apb_xfer(1'b0, 32'h0000_2014, 32'h0, 1'b0);
    resp_cfg = 2'b01; apb_xfer(1'b0, 32'h0000_2018, 32'h0, 1'b0);
    resp_cfg = 2'b10; apb_xfer(1'b1, 32'h0000_201C, 32'h1357_9BDF, 1'b0);
    ar_dly = 0; r_dly = 0;
    resp_cfg = 2'b00;
    rdata_cfg = 64'hA1B2_C3D4_E5F6_0718;
    apb_xfer(1'b0, 32'h0000_2020, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int cyc;
    b_dly = 6;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_5000; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!if32.b_ready_o && cyc < 100);
    n_tests++; if (if32.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL reach_wr_resp got=%b exp=1", if32.b_ready_o); end
    @(posedge clk); #1;
    rst = 1;
    #1;
    n_tests++;
    if ({if32.aw_valid_o, if32.w_valid_o, if32.b_ready_o, if32.ar_valid_o, if32.r_ready_o,
         if32.pready_o, if32.pslverr_o, if32.prdata_o,
         if64.aw_valid_o, if64.w_valid_o, if64.b_ready_o, if64.ar_valid_o, if64.r_ready_o,
         if64.pready_o, if64.pslverr_o, if64.prdata_o} !== 78'd0) begin
      n_fail++; $display("FAIL reset_mid got=%b%b prdata=%h/%h exp=0", if32.b_ready_o, if64.b_ready_o, if32.prdata_o, if64.prdata_o);
    end
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst = 0; b_dly = 0;
    @(posedge clk); #1;
    rdata_cfg = 64'h0102_0304_0506_0708;
    apb_xfer(1'b0, 32'h0000_6004, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    rdata_cfg = 64'h9988_7766_4433_2211;
    resp_cfg  = 2'b00;
    apb_xfer(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 1'b1);
    apb_xfer(1'b0, 32'h0000_0044, 32'h0, 1'b1);
    apb_xfer(1'b1, 32'h0000_0048, 32'h3C3C_C3C3, 1'b0);
  endtask

  initial begin
    test_reset;
    test_write_min;
    test_read_lane;
    test_wait_states;
    test_read_err;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
